// File: rtl/tc0260dar_pkg.sv
`default_nettype none
// ============================================================================
// Package  : tc0260dar_pkg
// Shared widths and CPU sequencer state encoding for the palette arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package tc0260dar_pkg;

    localparam int c_DEF_AW = 14;
    localparam int c_DEF_DW = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        RDWAIT = 2'd2,
        ACK    = 2'd3
    } cpu_state_t;

endpackage
`default_nettype wire

// File: rtl/tc0260dar_vidpipe.sv
`default_nettype none
// ============================================================================
// Module   : tc0260dar_vidpipe
// Two-stage video slot pipeline: slot detect, RAM capture, blank zeroing.
// Revision : 1.0 - initial release
// ============================================================================
module tc0260dar_vidpipe #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_ce_pixel,
    input  logic          i_hblank_n,
    input  logic          i_vblank_n,
    input  logic          i_steal,
    input  logic [DW-1:0] i_ram_rdata,
    output logic          o_slot,
    output logic [DW-1:0] o_vid_data,
    output logic          o_vid_valid
);

    logic          r_s1_ce;
    logic          r_s1_act;
    logic          r_s1_steal;
    logic [DW-1:0] r_vid_data;
    logic          r_vid_valid;

    assign o_slot      = i_ce_pixel & i_hblank_n & i_vblank_n;
    assign o_vid_data  = r_vid_data;
    assign o_vid_valid = r_vid_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_ce     <= 1'b0;
            r_s1_act    <= 1'b0;
            r_s1_steal  <= 1'b0;
            r_vid_data  <= '0;
            r_vid_valid <= 1'b0;
        end else begin
            r_s1_ce     <= i_ce_pixel;
            r_s1_act    <= o_slot;
            r_s1_steal  <= i_steal;
            r_vid_valid <= r_s1_ce;
            // A stolen slot leaves the previous palette word on screen.
            if (r_s1_ce && !r_s1_steal)
                r_vid_data <= r_s1_act ? i_ram_rdata : '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tc0260dar_arb.sv
`default_nettype none
// ============================================================================
// Module   : tc0260dar_arb
// Palette RAM time-slot arbiter: video read slot per pixel, CPU in free cycles.
// Option   : DAR_CPU_PRIORITY_EN lets a pending CPU access steal a video slot.
// Revision : 1.0 - initial release
// ============================================================================
module tc0260dar_arb
    import tc0260dar_pkg::*;
#(
    parameter int AW = c_DEF_AW,
    parameter int DW = c_DEF_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce_pixel,
    input  logic          hblank_n,
    input  logic          vblank_n,
    input  logic          cpu_cs,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    input  logic          cpu_rw_n,
    input  logic          cpu_uds_n,
    input  logic          cpu_lds_n,
    output logic          cpu_dtack_n,
    input  logic [AW-1:0] vid_index,
    output logic [DW-1:0] vid_data,
    output logic          vid_valid,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_rdata,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we_h_n,
    output logic          ram_we_l_n
`ifdef DAR_CPU_PRIORITY_EN
    ,
    output logic [15:0]   stolen_slots
`endif
);

    cpu_state_t    r_state;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          r_rw_n;
    logic          r_uds_n;
    logic          r_lds_n;
    logic [DW-1:0] r_dout;
    logic          r_dtack_n;

    logic          w_slot;
    logic          w_cpu_owns;
    logic          w_steal;
    logic          w_wr;

    tc0260dar_vidpipe #(.DW(DW)) u_vidpipe (
        .clk         (clk),
        .rst         (reset),
        .i_ce_pixel  (ce_pixel),
        .i_hblank_n  (hblank_n),
        .i_vblank_n  (vblank_n),
        .i_steal     (w_steal),
        .i_ram_rdata (ram_rdata),
        .o_slot      (w_slot),
        .o_vid_data  (vid_data),
        .o_vid_valid (vid_valid)
    );

`ifdef DAR_CPU_PRIORITY_EN
    logic [15:0] r_stolen;

    assign w_cpu_owns   = (r_state == PEND) & cpu_cs;
    assign w_steal      = w_cpu_owns & w_slot & ~reset;
    assign stolen_slots = r_stolen;

    always_ff @(posedge clk) begin
        if (reset)
            r_stolen <= '0;
        else if (w_steal && (r_stolen != 16'hFFFF))
            r_stolen <= r_stolen + 16'd1;
    end
`else
    assign w_cpu_owns = (r_state == PEND) & ~w_slot;
    assign w_steal    = 1'b0;
`endif

    // Strobes are gated by reset so an access interrupted by reset never writes.
    assign w_wr       = w_cpu_owns & cpu_cs & ~r_rw_n & ~reset;
    assign ram_addr   = w_cpu_owns ? r_addr : vid_index;
    assign ram_wdata  = r_data;
    assign ram_we_h_n = ~(w_wr & ~r_uds_n);
    assign ram_we_l_n = ~(w_wr & ~r_lds_n);

    assign cpu_dout    = r_dout;
    assign cpu_dtack_n = r_dtack_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_data    <= '0;
            r_rw_n    <= 1'b1;
            r_uds_n   <= 1'b1;
            r_lds_n   <= 1'b1;
            r_dout    <= '0;
            r_dtack_n <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cpu_cs) begin
                        r_addr  <= cpu_addr;
                        r_data  <= cpu_din;
                        r_rw_n  <= cpu_rw_n;
                        r_uds_n <= cpu_uds_n;
                        r_lds_n <= cpu_lds_n;
                        r_state <= PEND;
                    end
                end
                PEND: begin
                    if (!cpu_cs) begin
                        r_state <= IDLE;
                    end else if (w_cpu_owns) begin
                        if (r_rw_n) begin
                            r_state <= RDWAIT;
                        end else begin
                            r_state   <= ACK;
                            r_dtack_n <= 1'b0;
                        end
                    end
                end
                RDWAIT: begin
                    r_dout    <= ram_rdata;
                    r_state   <= ACK;
                    r_dtack_n <= 1'b0;
                end
                ACK: begin
                    if (!cpu_cs) begin
                        r_dtack_n <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tc0260dar_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_tc0260dar_arb
// Directed vector bench for the palette arbiter with a behavioural RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tc0260dar_arb;
    import tc0260dar_pkg::*;

    localparam int AW = 14;
    localparam int DW = 16;

    logic          clk;
    logic          reset;
    logic          ce_pixel, hblank_n, vblank_n;
    logic          cpu_cs, cpu_rw_n, cpu_uds_n, cpu_lds_n;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din, cpu_dout;
    logic          cpu_dtack_n;
    logic [AW-1:0] vid_index;
    logic [DW-1:0] vid_data;
    logic          vid_valid;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_rdata, ram_wdata;
    logic          ram_we_h_n, ram_we_l_n;
`ifdef DAR_CPU_PRIORITY_EN
    logic [15:0]   stolen_slots;
`endif

    tc0260dar_arb #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .ce_pixel    (ce_pixel),
        .hblank_n    (hblank_n),
        .vblank_n    (vblank_n),
        .cpu_cs      (cpu_cs),
        .cpu_addr    (cpu_addr),
        .cpu_din     (cpu_din),
        .cpu_dout    (cpu_dout),
        .cpu_rw_n    (cpu_rw_n),
        .cpu_uds_n   (cpu_uds_n),
        .cpu_lds_n   (cpu_lds_n),
        .cpu_dtack_n (cpu_dtack_n),
        .vid_index   (vid_index),
        .vid_data    (vid_data),
        .vid_valid   (vid_valid),
        .ram_addr    (ram_addr),
        .ram_rdata   (ram_rdata),
        .ram_wdata   (ram_wdata),
        .ram_we_h_n  (ram_we_h_n),
        .ram_we_l_n  (ram_we_l_n)
`ifdef DAR_CPU_PRIORITY_EN
        ,
        .stolen_slots(stolen_slots)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous single-port RAM: read data shows the previous cycle's address.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;

    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else begin
            if (!ram_we_h_n) mem[ram_addr][15:8] <= ram_wdata[15:8];
            if (!ram_we_l_n) mem[ram_addr][7:0]  <= ram_wdata[7:0];
        end
        ram_rdata <= mem[ram_addr];
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (step %0d): got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic cyc(input logic ce, input logic cs);
        @(negedge clk);
        ce_pixel = ce;
        cpu_cs   = cs;
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
    endtask

    typedef struct packed {
        logic          ce;
        logic          hb;
        logic          cs;
        logic          rw;
        logic          uds;
        logic          lds;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic          e_dtack;
        logic          e_weh;
        logic          e_wel;
        logic          e_vv;
        logic [DW-1:0] e_vd;
        logic [AW-1:0] e_raddr;
        logic [DW-1:0] e_dout;
    } vec_t;

    function automatic vec_t mk(input logic ce, hb, cs, rw, uds, lds,
                                input logic [AW-1:0] addr, input logic [DW-1:0] din,
                                input logic dt, weh, wel, vv,
                                input logic [DW-1:0] vd, input logic [AW-1:0] ra,
                                input logic [DW-1:0] dout);
        vec_t v;
        v = '{ce, hb, cs, rw, uds, lds, addr, din, dt, weh, wel, vv, vd, ra, dout};
        return v;
    endfunction

    vec_t tbl [14];
    int   lat;

    initial begin
        reset = 1'b1; ce_pixel = 1'b0; hblank_n = 1'b1; vblank_n = 1'b1;
        cpu_cs = 1'b0; cpu_rw_n = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
        cpu_addr = '0; cpu_din = '0; vid_index = 14'h0010;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;

        for (int i = 0; i < 16; i++) load(14'h0700 + 14'(i), 16'h0000);
        load(14'h0010, 16'hF0A5);
        load(14'h0200, 16'h7C1E);
        load(14'h0300, 16'h3456);
        load(14'h0123, 16'h0000);
        @(negedge clk);
        ld_en = 1'b0;
        @(negedge clk);
        #1;
        chk("reset dtack_n", 0, 32'(cpu_dtack_n), 32'h1);
        chk("reset dout", 0, 32'(cpu_dout), 32'h0);
        chk("reset vid_data", 0, 32'(vid_data), 32'h0);
        chk("reset vid_valid", 0, 32'(vid_valid), 32'h0);
        chk("reset we_h_n", 0, 32'(ram_we_h_n), 32'h1);
        chk("reset we_l_n", 0, 32'(ram_we_l_n), 32'h1);
`ifdef DAR_CPU_PRIORITY_EN
        chk("reset stolen", 0, 32'(stolen_slots), 32'h0);
`endif
        @(negedge clk);
        reset = 1'b0;

        //            ce hb cs rw u  l  addr      din       dt we_h we_l vv vd        raddr     dout
        tbl[0]  = mk(1, 1, 0, 1, 1, 1, 14'h0000, 16'h0000, 1, 1, 1, 0, 16'h0000, 14'h0010, 16'h0000);
        tbl[1]  = mk(0, 1, 0, 1, 1, 1, 14'h0000, 16'h0000, 1, 1, 1, 0, 16'h0000, 14'h0010, 16'h0000);
        tbl[2]  = mk(1, 1, 1, 0, 0, 0, 14'h0123, 16'hBEEF, 1, 1, 1, 1, 16'hF0A5, 14'h0010, 16'h0000);
        tbl[3]  = mk(0, 1, 1, 0, 0, 0, 14'h0123, 16'hBEEF, 1, 0, 0, 0, 16'hF0A5, 14'h0123, 16'h0000);
        tbl[4]  = mk(1, 1, 1, 0, 0, 0, 14'h0123, 16'hBEEF, 0, 1, 1, 1, 16'hF0A5, 14'h0010, 16'h0000);
        tbl[5]  = mk(0, 1, 0, 1, 1, 1, 14'h0000, 16'h0000, 0, 1, 1, 0, 16'hF0A5, 14'h0010, 16'h0000);
        tbl[6]  = mk(1, 1, 0, 1, 1, 1, 14'h0000, 16'h0000, 1, 1, 1, 1, 16'hF0A5, 14'h0010, 16'h0000);
        tbl[7]  = mk(0, 0, 0, 1, 1, 1, 14'h0000, 16'h0000, 1, 1, 1, 0, 16'hF0A5, 14'h0010, 16'h0000);
        tbl[8]  = mk(1, 0, 1, 1, 1, 1, 14'h0200, 16'h0000, 1, 1, 1, 1, 16'hF0A5, 14'h0010, 16'h0000);
        tbl[9]  = mk(0, 0, 1, 1, 1, 1, 14'h0200, 16'h0000, 1, 1, 1, 0, 16'hF0A5, 14'h0200, 16'h0000);
        tbl[10] = mk(1, 0, 1, 1, 1, 1, 14'h0200, 16'h0000, 1, 1, 1, 1, 16'h0000, 14'h0010, 16'h0000);
        tbl[11] = mk(0, 0, 1, 1, 1, 1, 14'h0200, 16'h0000, 0, 1, 1, 0, 16'h0000, 14'h0010, 16'h7C1E);
        tbl[12] = mk(0, 0, 0, 1, 1, 1, 14'h0000, 16'h0000, 0, 1, 1, 1, 16'h0000, 14'h0010, 16'h7C1E);
        tbl[13] = mk(0, 0, 0, 1, 1, 1, 14'h0000, 16'h0000, 1, 1, 1, 0, 16'h0000, 14'h0010, 16'h7C1E);

        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            ce_pixel = tbl[k].ce;  hblank_n = tbl[k].hb;  cpu_cs = tbl[k].cs;
            cpu_rw_n = tbl[k].rw;  cpu_uds_n = tbl[k].uds; cpu_lds_n = tbl[k].lds;
            cpu_addr = tbl[k].addr; cpu_din = tbl[k].din;
            #1;
            chk("dtack_n", k, 32'(cpu_dtack_n), 32'(tbl[k].e_dtack));
            chk("we_h_n", k, 32'(ram_we_h_n), 32'(tbl[k].e_weh));
            chk("we_l_n", k, 32'(ram_we_l_n), 32'(tbl[k].e_wel));
            chk("vid_valid", k, 32'(vid_valid), 32'(tbl[k].e_vv));
            chk("vid_data", k, 32'(vid_data), 32'(tbl[k].e_vd));
            chk("ram_addr", k, 32'(ram_addr), 32'(tbl[k].e_raddr));
            chk("cpu_dout", k, 32'(cpu_dout), 32'(tbl[k].e_dout));
        end
        chk("mem 0123 after write", 100, 32'(mem[14'h0123]), 32'h0000BEEF);
        hblank_n = 1'b1;

        // Upper-byte-only write
        cpu_addr = 14'h0300; cpu_din = 16'h12FF; cpu_rw_n = 1'b0; cpu_uds_n = 1'b0; cpu_lds_n = 1'b1;
        cyc(0, 1);
        cyc(0, 1);
        chk("uds write we_h_n", 200, 32'(ram_we_h_n), 32'h0);
        chk("uds write we_l_n", 200, 32'(ram_we_l_n), 32'h1);
        cyc(0, 1);
        chk("uds write dtack_n", 201, 32'(cpu_dtack_n), 32'h0);
        cyc(0, 0);
        cyc(0, 0);
        chk("uds write release", 202, 32'(cpu_dtack_n), 32'h1);
        chk("mem 0300 byte merge", 203, 32'(mem[14'h0300]), 32'h00001256);

        // Abort while pending
        cpu_addr = 14'h0400; cpu_din = 16'hAAAA; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0;
        cyc(0, 1);
        cyc(0, 0);
        chk("abort we_h_n", 300, 32'(ram_we_h_n), 32'h1);
        chk("abort we_l_n", 300, 32'(ram_we_l_n), 32'h1);
        cyc(0, 0);
        chk("abort dtack_n", 301, 32'(cpu_dtack_n), 32'h1);
        chk("abort state", 301, 32'(dut.r_state), 32'(IDLE));
        cyc(0, 0);
        chk("abort dtack_n later", 302, 32'(cpu_dtack_n), 32'h1);
        chk("abort mem 0400", 303, 32'(mem[14'h0400]), 32'h0);

        // Reset while pending
        cpu_addr = 14'h0500; cpu_din = 16'h5555;
        cyc(0, 1);
        @(negedge clk);
        reset = 1'b1; cpu_cs = 1'b1;
        #1;
        chk("reset-pend we_h_n", 400, 32'(ram_we_h_n), 32'h1);
        chk("reset-pend we_l_n", 400, 32'(ram_we_l_n), 32'h1);
        @(negedge clk);
        reset = 1'b0; cpu_cs = 1'b0;
        #1;
        chk("reset-pend dtack_n", 401, 32'(cpu_dtack_n), 32'h1);
        chk("reset-pend state", 401, 32'(dut.r_state), 32'(IDLE));
        chk("reset-pend vid_data", 401, 32'(vid_data), 32'h0);
        chk("reset-pend mem 0500", 402, 32'(mem[14'h0500]), 32'h0);

`ifndef DAR_CPU_PRIORITY_EN
        // Worst-case write: the first pending cycle is a video slot
        cpu_addr = 14'h0600; cpu_din = 16'h0F0F; cpu_rw_n = 1'b0; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0;
        cyc(0, 1);
        cyc(1, 1);
        chk("slot blocks we_h_n", 500, 32'(ram_we_h_n), 32'h1);
        chk("slot blocks we_l_n", 500, 32'(ram_we_l_n), 32'h1);
        chk("slot owns ram_addr", 500, 32'(ram_addr), 32'h0010);
        cyc(0, 1);
        chk("late write we_h_n", 501, 32'(ram_we_h_n), 32'h0);
        chk("late write ram_addr", 501, 32'(ram_addr), 32'h0600);
        cyc(0, 1);
        chk("write worst latency", 502, 32'(cpu_dtack_n), 32'h0);
        cyc(0, 0);
        cyc(0, 0);

        // Worst-case read latency, bounded wait
        cpu_addr = 14'h0200; cpu_rw_n = 1'b1; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0;
        cyc(0, 1);
        cyc(1, 1);
        lat = 11;
        for (int n = 2; n <= 10; n++) begin
            cyc(0, 1);
            if (!cpu_dtack_n) begin
                lat = n;
                break;
            end
        end
        chk("read worst latency", 600, 32'(lat), 32'd4);
        chk("read worst dout", 600, 32'(cpu_dout), 32'h7C1E);
        cyc(0, 0);
        cyc(0, 0);
`else
        // Pending write steals a video slot; the old pixel is held
        vid_index = 14'h0010;
        cyc(1, 0);
        cyc(0, 0);
        cyc(0, 0);
        chk("pre-steal vid_data", 700, 32'(vid_data), 32'hF0A5);
        vid_index = 14'h0200;
        cpu_addr = 14'h0700; cpu_din = 16'hCAFE; cpu_rw_n = 1'b0; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0;
        cyc(0, 1);
        cyc(1, 1);
        chk("steal we_h_n", 701, 32'(ram_we_h_n), 32'h0);
        chk("steal ram_addr", 701, 32'(ram_addr), 32'h0700);
        cyc(0, 1);
        chk("steal dtack_n", 702, 32'(cpu_dtack_n), 32'h0);
        chk("stolen_slots", 702, 32'(stolen_slots), 32'h1);
        cyc(0, 1);
        chk("steal vid_valid", 703, 32'(vid_valid), 32'h1);
        chk("steal vid_data held", 703, 32'(vid_data), 32'hF0A5);
        cyc(0, 0);
        cyc(0, 0);
        chk("steal mem 0700", 704, 32'(mem[14'h0700]), 32'h0000CAFE);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tc0260dar_arb.md
Name: tc0260dar_arb

Overview:
- Time-slot arbiter and sequencer for the single-port palette RAM, shared by the 68000 CPU and the video colour-index lookup.
- Sits between the CPU bus decode, the video mixer index output (IM) and the palette block RAM.
- Gives video a guaranteed read slot on every active-display pixel and runs CPU accesses in the remaining cycles.
- CPU accesses complete with a real DTACK handshake instead of zero-wait.

Parameters:
- AW, 14, palette RAM address width
- DW, 16, palette RAM data width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce_pixel  in  1  pixel clock enable; never asserted in two consecutive clk cycles
- hblank_n  in  1  active-low horizontal blank
- vblank_n  in  1  active-low vertical blank
- cpu_cs  in  1  palette chip select, held for the whole bus cycle
- cpu_addr  in  AW  CPU word address
- cpu_din  in  DW  CPU write data
- cpu_dout  out  DW  registered CPU read data
- cpu_rw_n  in  1  1 = read, 0 = write
- cpu_uds_n  in  1  upper byte strobe, active low
- cpu_lds_n  in  1  lower byte strobe, active low
- cpu_dtack_n  out  1  data acknowledge, active low
- vid_index  in  AW  colour index from the mixer
- vid_data  out  DW  palette word for the current pixel
- vid_valid  out  1  one-cycle pulse when vid_data updates
- ram_addr  out  AW  RAM address
- ram_rdata  in  DW  RAM read data; reflects the previous cycle's ram_addr
- ram_wdata  out  DW  RAM write data
- ram_we_h_n  out  1  upper byte write enable, active low
- ram_we_l_n  out  1  lower byte write enable, active low

Behaviour:
- Reset values: cpu_dout = 0, cpu_dtack_n = 1, vid_data = 0, vid_valid = 0, ram_we_*_n = 1, FSM = IDLE.
- Reset asserted mid-access drops any pending write with no RAM strobe.
- Video slot: a cycle T with ce_pixel & hblank_n & vblank_n.
  - In T, ram_addr = vid_index.
  - In T+1, ram_rdata is registered into vid_data.
  - At T+2, vid_data is valid and vid_valid pulses for 1 cycle.
- Blanked slot: ce_pixel with either blank active.
  - vid_data is loaded with 0 and vid_valid pulses 2 cycles later, matching the active-slot latency.
  - The RAM is free for the CPU in that cycle.
- Free cycle: any cycle that is not a video slot. ram_addr = latched CPU address when the FSM is in PEND; otherwise it follows vid_index.
- CPU FSM:
  - IDLE: on cpu_cs = 1, latch address, data, rw and the two strobes, then go to PEND.
  - PEND: if cpu_cs = 0, abort to IDLE with no write. Otherwise, on the first free cycle, drive the latched address:
    - Write: ram_we_h_n = uds_n and ram_we_l_n = lds_n for exactly that cycle; ram_wdata = latched data; go to ACK.
    - Read: go to RDWAIT.
  - RDWAIT: capture ram_rdata into cpu_dout, then go to ACK. This is valid even when the RDWAIT cycle is a video slot.
  - ACK: cpu_dtack_n = 0. When cpu_cs = 0, cpu_dtack_n = 1 and the FSM returns to IDLE. A new access needs cpu_cs low for at least 1 cycle.
- Write-enable rules:
  - A write with both strobes high generates no RAM write but still acknowledges.
  - The write enables are never low during a video slot, and never low outside PEND.
- Latency bounds (worst case, from cpu_cs assertion to cpu_dtack_n low):
  - Write: 3 clk.
  - Read: 4 clk.
- Simultaneous cpu_cs and video slot: video wins and the CPU proceeds in the next cycle.

Optional Feature:
- Macro: DAR_CPU_PRIORITY_EN
- Defined: a PEND access takes the RAM even in a video slot. That slot is lost, and vid_data keeps its previous value, reproducing hardware palette "snow". vid_valid still pulses. A 16-bit saturating output, stolen_slots, counts lost slots and clears on reset.
- Undefined: video always wins and the stolen_slots port is absent.

Decomposition:
- Package tc0260dar_pkg: AW/DW defaults and the cpu_state_t enum {IDLE, PEND, RDWAIT, ACK}.
- One natural sub-module, tc0260dar_vidpipe: the 2-stage video slot and capture pipeline (slot detect, blank zeroing, vid_valid).
- The CPU FSM and RAM mux stay in the top.

Test Plan:
- Active line with ce_pixel every 2 clk, vid_index 0x0010, RAM[0x0010] = 0xF0A5 -> vid_data = 0xF0A5 with vid_valid 2 clk after each slot; write enables stay high.
- CPU write addr 0x0123, data 0xBEEF, both strobes low, issued in the slot cycle -> write lands the next cycle; RAM = 0xBEEF; dtack low within 3 clk; video pixel unaffected.
- CPU write with only uds_n low, data 0x12FF onto RAM 0x3456 -> RAM = 0x1256.
- CPU read of addr 0x0200 (RAM = 0x7C1E) during blanking -> cpu_dout = 0x7C1E; dtack low 3 clk after cs; vid_data = 0.
- cpu_cs drops while in PEND; separately, reset asserted in PEND -> no write strobe, dtack stays 1, FSM returns to IDLE.
- With DAR_CPU_PRIORITY_EN: write coincident with a video slot -> write in the same cycle, vid_data holds its old value, stolen_slots = 1.
